// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and sizing helpers for the synchronous FIFO.
//   DEFAULT_WIDTH  : default bit width of a stored word
//   DEFAULT_LENGTH : default number of storage entries
//   ptr_width()    : bits needed to index 'length' entries (never below 1)
//   cnt_width()    : bits needed to hold an occupancy of 0..length
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32'd8;
  localparam int unsigned DEFAULT_LENGTH = 32'd4;

  // Pointer width: clog2(length), with a floor of one bit.
  function automatic int unsigned ptr_width(input int unsigned len);
    if (len <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(len);
    end
  endfunction

  // Occupancy width: must represent the value 'length' itself.
  function automatic int unsigned cnt_width(input int unsigned len);
    return $clog2(len + 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered read port.
// Parameters:
//   width  : bits per word
//   length : number of entries (>= 2, need not be a power of two)
// Ports:
//   clock        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   data_in      in   word to enqueue
//   write_enable in   enqueue request
//   read_enable  in   dequeue request
//   data_out     out  last dequeued word (registered, holds between reads)
//   full         out  occupancy == length
//   empty        out  occupancy == 0
// ---------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned width  = DEFAULT_WIDTH,
  parameter int unsigned length = DEFAULT_LENGTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [width-1:0] data_in,
  input  logic             write_enable,
  input  logic             read_enable,
  output logic [width-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = ptr_width(length);
  localparam int unsigned CW = cnt_width(length);

  // Wrap is decided by comparing against the last index, so a
  // non-power-of-two length wraps correctly.
  localparam logic [PW-1:0] PTR_LAST = PW'(length - 32'd1);
  localparam logic [CW-1:0] CNT_FULL = CW'(length);

  logic [width-1:0] mem_q [length];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [width-1:0] data_q,   data_d;

  logic full_s;
  logic empty_s;
  logic wr_accept_s;
  logic rd_accept_s;

  // Status decode and accept decisions, all from occupancy before the edge.
  always_comb begin
    full_s  = (count_q == CNT_FULL);
    empty_s = (count_q == {CW{1'b0}});
    rd_accept_s = read_enable & ~empty_s;
    // When full, a simultaneous read frees the slot the write lands in.
    wr_accept_s = write_enable & (~full_s | read_enable);
  end

  // Next-state for pointers, occupancy and the output word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;

    if (wr_accept_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PW{1'b0}} : (wr_ptr_q + PW'(1));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_accept_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PW{1'b0}} : (rd_ptr_q + PW'(1));
      data_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      data_d   = data_q;
    end

    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and output register; cleared asynchronously.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      data_q   <= {width{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  // Storage array; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clock) begin
    if (wr_accept_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = data_q;
  assign full     = full_s;
  assign empty    = empty_s;

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
// Self-checking bench for sync_fifo (width 8, length 4). A queue-based
// behavioural model tracks the FIFO and is compared against the DUT at every
// falling clock edge; directed sequences also pin literal expected values.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int unsigned W   = 8;
  localparam int unsigned LEN = 4;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         write_enable = 1'b0;
  logic         read_enable = 1'b0;
  logic [W-1:0] data_out;
  logic         full;
  logic         empty;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_dout = '0;

  sync_fifo #(.width(W), .length(LEN)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue semantics, decisions from occupancy before the edge.
  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_q.delete();
        m_dout = '0;
      end else begin
        int  occ;
        bit  ra;
        bit  wa;
        occ = m_q.size();
        ra  = read_enable && (occ > 0);
        wa  = write_enable && ((occ < LEN) || read_enable);
        if (ra) m_dout = m_q.pop_front();
        if (wa) m_q.push_back(data_in);
      end
    end
  end

  // Lock-step compare on every falling edge.
  initial begin
    forever begin
      @(negedge clock);
      chk("cyc_dout",  {24'd0, data_out}, {24'd0, m_dout});
      chk("cyc_full",  {31'd0, full},  {31'd0, (m_q.size() == LEN)});
      chk("cyc_empty", {31'd0, empty}, {31'd0, (m_q.size() == 0)});
    end
  end

  // Drive one cycle of inputs, then land 1 time unit after the next posedge.
  task automatic step(input logic we, input logic re, input logic [W-1:0] d);
    write_enable = we;
    read_enable  = re;
    data_in      = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [W-1:0] v;

    // Reset for one cycle
    @(posedge clock);
    #1;
    resetn = 1'b1;
    chk("rst_dout",  {24'd0, data_out}, 32'h0);
    chk("rst_empty", {31'd0, empty}, 32'h1);
    chk("rst_full",  {31'd0, full},  32'h0);
    step(1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 8'hEE);
    chk("idle_dout", {24'd0, data_out}, 32'h0);

    // Fill then drain
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    chk("fill3_full", {31'd0, full}, 32'h0);
    step(1'b1, 1'b0, 8'h44);
    chk("fill4_full", {31'd0, full}, 32'h1);
    step(1'b1, 1'b0, 8'h55);
    chk("drop_full", {31'd0, full}, 32'h1);
    step(1'b0, 1'b1, 8'h00); chk("drain0", {24'd0, data_out}, 32'h11);
    step(1'b0, 1'b1, 8'h00); chk("drain1", {24'd0, data_out}, 32'h22);
    step(1'b0, 1'b1, 8'h00); chk("drain2", {24'd0, data_out}, 32'h33);
    step(1'b0, 1'b1, 8'h00); chk("drain3", {24'd0, data_out}, 32'h44);
    chk("drained_empty", {31'd0, empty}, 32'h1);
    step(1'b0, 1'b1, 8'h00); chk("rd_empty_hold", {24'd0, data_out}, 32'h44);

    // Simultaneous read+write when empty: no bypass
    step(1'b1, 1'b1, 8'hA5);
    chk("emp_rw_dout",  {24'd0, data_out}, 32'h44);
    chk("emp_rw_empty", {31'd0, empty}, 32'h0);
    step(1'b0, 1'b1, 8'h00);
    chk("emp_rw_next", {24'd0, data_out}, 32'hA5);
    chk("emp_rw_emp2", {31'd0, empty}, 32'h1);

    // Simultaneous read+write when full
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, W'(i));
    step(1'b1, 1'b1, 8'h05);
    chk("full_rw_dout", {24'd0, data_out}, 32'h1);
    chk("full_rw_full", {31'd0, full}, 32'h1);
    for (int i = 2; i <= 5; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("full_rw_drain", {24'd0, data_out}, i);
    end
    chk("full_rw_empty", {31'd0, empty}, 32'h1);

    // Pointer wrap with alternating write/read
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, W'(i));
      step(1'b0, 1'b1, 8'h00);
      chk("wrap", {24'd0, data_out}, i);
    end

    // Asynchronous reset between edges mid-stream
    step(1'b1, 1'b0, 8'h77);
    step(1'b1, 1'b1, 8'h88);
    chk("pre_arst_dout", {24'd0, data_out}, 32'h77);
    #1 resetn = 1'b0;
    #1;
    chk("arst_dout",  {24'd0, data_out}, 32'h0);
    chk("arst_empty", {31'd0, empty}, 32'h1);
    chk("arst_full",  {31'd0, full},  32'h0);
    resetn = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    chk("arst_rd_ignored", {24'd0, data_out}, 32'h0);

    // Randomized lock-step run, biased to visit both full and empty
    for (int i = 0; i < 10000; i++) begin
      int wp;
      wp = ((i / 500) % 2 == 0) ? 70 : 30;
      v  = W'($urandom);
      step(($urandom_range(99) < wp), ($urandom_range(99) < (100 - wp)), v);
    end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parameterised-width, parameterised-depth first-in/first-out buffer.
- Used as the byte buffer in the buffered UART path.
- Connected through the shared interface fifo_if, which carries all signals below.
- A non-synthesisable behavioural twin, sync_fifo_model, has the identical interface and is used for lock-step comparison in benches.

Parameters:
- width, 8, bit width of each stored word and of data_in/data_out.
- length, 4, number of storage entries; any value >= 2 is legal, power of two not required.

Ports:
- One clock; reset is asynchronous and active-low. The clock port is named clock and the reset port is named resetn.
- clock  input  1  rising-edge clock for all state.
- resetn  input  1  asynchronous active-low reset.
- data_in  input  width  word to enqueue.
- write_enable  input  1  enqueue request, sampled at posedge clock.
- read_enable  input  1  dequeue request, sampled at posedge clock.
- data_out  output  width  registered dequeued word.
- full  output  1  occupancy == length.
- empty  output  1  occupancy == 0.

Behaviour:
- Reset (resetn low, asynchronous):
  - occupancy = 0, read and write pointers = 0.
  - data_out = 0, empty = 1, full = 0.
  - Storage contents need not be cleared.
  - Reset may assert at any time, including mid-stream; all queued data is discarded.
- All other state updates on posedge clock only.
- Write:
  - If write_enable = 1 and the FIFO is not full, store data_in at the write pointer and advance it.
  - A write to a full FIFO is silently dropped; no state changes.
- Read:
  - If read_enable = 1 and the FIFO is not empty, load the oldest entry into data_out on that edge and advance the read pointer.
  - Latency: the word is visible on data_out immediately after the edge where the read was accepted.
  - A read from an empty FIFO is ignored and data_out holds its previous value.
- data_out changes only on an accepted read or on reset; otherwise it holds.
- Pointers wrap from length-1 to 0. This must be correct for non-power-of-two length, e.g. compare against length-1, not bit truncation.
- Occupancy counter:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous read and write:
  - Empty: the write is accepted and the read is rejected. There is no bypass; data_out holds and the new word becomes readable next cycle.
  - Full: the read is accepted. The write is also accepted into the slot being freed, so occupancy stays at length.
  - Otherwise: both accepted, occupancy unchanged.
- full and empty are combinational decodes of the registered occupancy.
- Accept decisions use occupancy before the edge.
- sync_fifo_model must produce bit-identical data_out every cycle for the same stimulus. It is queue-based and implements the same rules.

Decomposition:
- Package fifo_pkg holds:
  - default width/length constants;
  - a pointer-width function, clog2 of length with minimum 1;
  - a count width of clog2(length+1).
- Interface fifo_if holds the parameters and signals above. It has a modport for the FIFO (clock/resetn/data_in/enables input, data_out/full/empty output) and a modport for the driver.
- No sub-module is needed; storage is an internal array.
- sync_fifo_model is a separate behavioural module, bench-only.

Test Plan:
- Reset: hold resetn = 0 for 1 cycle, then release -> data_out = 0, empty = 1, full = 0; no data_out change while enables stay 0.
- Fill then drain, width 8, length 4:
  - Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> full = 1 after the 4th edge.
  - A 5th write of 0x55 -> dropped.
  - Four reads -> data_out 0x11, 0x22, 0x33, 0x44 on successive edges; empty = 1.
  - A 5th read -> data_out stays 0x44.
- Empty simultaneous read and write:
  - From empty, read+write of 0xA5 -> data_out unchanged, occupancy 1.
  - Next-cycle read -> data_out = 0xA5.
- Full simultaneous read and write:
  - Fill with 1, 2, 3, 4, then read+write of 5 -> data_out = 1, full stays 1.
  - Draining gives 2, 3, 4, 5.
- Wrap and async reset:
  - 10 alternating write/read pairs with values 0..9 -> each read returns the matching value across pointer wrap.
  - resetn pulsed low between clock edges mid-stream -> data_out = 0 and empty = 1 immediately.
- Random lock-step: 10k cycles of random data_in/read_enable/write_enable into sync_fifo and sync_fifo_model -> zero data_out mismatches at every posedge.
